// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - function codes and mult/div op kinds for the execute-stage ALU
package alu_exec_unit_pkg;

  localparam logic [5:0] FUNC_ADD      = 6'b100000;
  localparam logic [5:0] FUNC_SUBU     = 6'b100011;
  localparam logic [5:0] FUNC_AND      = 6'b100100;
  localparam logic [5:0] FUNC_OR       = 6'b100101;
  localparam logic [5:0] FUNC_XOR      = 6'b100110;
  localparam logic [5:0] FUNC_NOR      = 6'b100111;
  localparam logic [5:0] FUNC_SLT      = 6'b101010;
  localparam logic [5:0] FUNC_SHIFTLUI = 6'b001111;
  localparam logic [5:0] FUNC_MFHI     = 6'b010000;
  localparam logic [5:0] FUNC_MFLO     = 6'b010010;
  localparam logic [5:0] FUNC_MULT     = 6'b011000;
  localparam logic [5:0] FUNC_MULTU    = 6'b011001;
  localparam logic [5:0] FUNC_DIV      = 6'b011010;
  localparam logic [5:0] FUNC_DIVU     = 6'b011011;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_e;

  function automatic logic md_is_div(input muldiv_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input muldiv_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiply / restoring divide owning HI and LO
module alu_muldiv_iter
  import alu_exec_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  muldiv_op_e         i_op,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  muldiv_op_e           op_q, op_d;
  logic [NB_DATA-1:0]   acc_hi_q, acc_hi_d;
  logic [NB_DATA-1:0]   acc_lo_q, acc_lo_d;
  logic [NB_DATA-1:0]   divisor_q, divisor_d;
  logic [NB_DATA-1:0]   dividend_q, dividend_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic [NB_DATA-1:0]   hi_q, hi_d;
  logic [NB_DATA-1:0]   lo_q, lo_d;

  logic [NB_DATA:0]     div_tmp;
  logic [NB_DATA:0]     div_diff;
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] prod;
  logic [NB_DATA-1:0]   quot;
  logic [NB_DATA-1:0]   rem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    // acc_hi holds the partial product high half or the running remainder
    div_tmp  = {acc_hi_q, acc_lo_q[NB_DATA-1]};
    div_diff = div_tmp - {1'b0, divisor_q};
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, divisor_q} : '0);
    prod     = {acc_hi_q, acc_lo_q};
    if (a_neg_q ^ b_neg_q) prod = -prod;
    quot     = (a_neg_q ^ b_neg_q) ? -acc_lo_q : acc_lo_q;
    rem      = a_neg_q ? -acc_hi_q : acc_hi_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d       = i_op;
          a_neg_d    = md_is_signed(i_op) & i_op_a[NB_DATA-1];
          b_neg_d    = md_is_signed(i_op) & i_op_b[NB_DATA-1];
          acc_lo_d   = a_neg_d ? -i_op_a : i_op_a;
          divisor_d  = b_neg_d ? -i_op_b : i_op_b;
          dividend_d = i_op_a;
          acc_hi_d   = '0;
          cnt_d      = '0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (md_is_div(op_q)) begin
          if (div_tmp >= {1'b0, divisor_q}) begin
            acc_hi_d = div_diff[NB_DATA-1:0];
            acc_lo_d = {acc_lo_q[NB_DATA-2:0], 1'b1};
          end else begin
            acc_hi_d = div_tmp[NB_DATA-1:0];
            acc_lo_d = {acc_lo_q[NB_DATA-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[NB_DATA:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[NB_DATA-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (md_is_div(op_q)) begin
          // divide by zero reports the raw dividend instead of a sign-fixed remainder
          if (divisor_q == '0) begin
            lo_d = '1;
            hi_d = dividend_q;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= MD_MULT;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_FIX);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU: decode, single-cycle ops and valid/ready handshake
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_FUNC = 6,
  parameter int NB_CNT  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_FUNC-1:0] i_alu_func,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_done,
  output logic               o_illegal
);

  logic               ready_en_q, ready_en_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic               accept;
  logic               is_md;
  logic               sc_ill;
  logic [NB_DATA-1:0] sc_res;
  logic               md_start;
  muldiv_op_e         md_op;
  logic               md_busy;
  logic [NB_DATA-1:0] md_hi, md_lo;

  always_comb begin
    is_md  = 1'b0;
    md_op  = MD_MULT;
    sc_ill = 1'b0;
    sc_res = '0;
    case (i_alu_func)
      FUNC_ADD:      sc_res = i_op_a + i_op_b;
      FUNC_SUBU:     sc_res = i_op_a - i_op_b;
      FUNC_AND:      sc_res = i_op_a & i_op_b;
      FUNC_OR:       sc_res = i_op_a | i_op_b;
      FUNC_XOR:      sc_res = i_op_a ^ i_op_b;
      FUNC_NOR:      sc_res = ~(i_op_a | i_op_b);
      FUNC_SLT:      sc_res = {{(NB_DATA-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      FUNC_SHIFTLUI: sc_res = i_op_b << 16;
      FUNC_MFHI:     sc_res = md_hi;
      FUNC_MFLO:     sc_res = md_lo;
      FUNC_MULT:     begin is_md = 1'b1; md_op = MD_MULT;  end
      FUNC_MULTU:    begin is_md = 1'b1; md_op = MD_MULTU; end
      FUNC_DIV:      begin is_md = 1'b1; md_op = MD_DIV;   end
      FUNC_DIVU:     begin is_md = 1'b1; md_op = MD_DIVU;  end
      default:       sc_ill = 1'b1;
    endcase
  end

  // o_ready stays low in reset and rises on the first edge after release
  assign o_ready = ready_en_q & ~md_busy;
  assign accept  = i_valid & o_ready;

  always_comb begin
    ready_en_d = 1'b1;
    md_start   = accept & is_md;
    valid_d    = accept & ~is_md;
    illegal_d  = valid_d & sc_ill;
    result_d   = valid_d ? sc_res : result_q;
    zero_d     = valid_d ? (sc_res == '0) : zero_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ready_en_q <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
    end
  end

  alu_muldiv_iter #(
    .NB_DATA (NB_DATA),
    .NB_CNT  (NB_CNT)
  ) u_muldiv (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (md_start),
    .i_op    (md_op),
    .i_op_a  (i_op_a),
    .i_op_b  (i_op_b),
    .o_busy  (md_busy),
    .o_done  (o_done),
    .o_hi    (md_hi),
    .o_lo    (md_lo)
  );

  assign o_valid   = valid_q;
  assign o_result  = result_q;
  assign o_zero    = zero_q;
  assign o_illegal = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 6-bit function code produced by alu_control and the two 32-bit operands, and returns a registered result.
- Single-cycle ops: ADD, SUBU, AND, OR, XOR, NOR, SLT, SHIFTLUI, MFHI, MFLO; result one cycle after accept.
- Multi-cycle ops: MULT, MULTU, DIV, DIVU run iteratively and write internal HI/LO registers.
- Stalls the pipeline through a valid/ready handshake while an iterative op runs.

Parameters:
NB_DATA, 32, operand/result width
NB_FUNC, 6, function code width (matches alu_control output)
NB_CNT, 5, iteration counter width (log2 NB_DATA)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  operation request
o_ready  out  1  unit can accept a request this cycle
i_alu_func  in  NB_FUNC  function code
i_op_a  in  NB_DATA  rs operand
i_op_b  in  NB_DATA  rt / immediate operand
o_valid  out  1  o_result valid (single-cycle pulse)
o_result  out  NB_DATA  registered result
o_zero  out  1  o_result == 0, qualified by o_valid
o_done  out  1  one-cycle pulse: HI/LO updated by mult/div
o_illegal  out  1  one-cycle pulse: unsupported func code accepted

Behaviour:
- Reset (async, i_reset=0):
  - FSM to IDLE; HI=LO=0; counter=0.
  - o_result=0, o_valid=0, o_zero=0, o_done=0, o_illegal=0, o_ready=0 while in reset.
  - o_ready=1 from the first clock edge after release.
  - Reset mid-operation aborts it; HI/LO do not retain partial values.
- Accept: a request is accepted on a rising edge where i_valid && o_ready. i_valid with o_ready=0 is ignored; the requester holds the request.
- Single-cycle ops (latency 1):
  - o_valid=1 and o_result set on the edge after accept; o_ready stays 1 (back-to-back accepts every cycle).
  - ADD: a+b. SUBU: a-b. Both wrap mod 2^32, no trap.
  - AND, OR, XOR: bitwise. NOR: ~(a|b).
  - SLT: signed a<b gives 1, else 0. SHIFTLUI: b<<16.
  - MFHI / MFLO: current HI / LO.
- Mult/div ops (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011):
  - No o_valid. FSM IDLE→CALC→FIX→IDLE.
  - CALC: 32 cycles. Shift-add multiply, or restoring divide on operand magnitudes (signed ops take abs).
  - FIX: 1 cycle. Sign correction, HI/LO written, o_done=1.
  - o_ready=0 for exactly 33 cycles after the accept edge, then returns to 1.
  - MFHI/MFLO accepted on that first ready cycle returns the new values.
- Mult/div results:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO=quotient, HI=remainder. For signed ops the remainder takes the dividend's sign; the quotient truncates toward zero.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend, no trap, same 33-cycle latency.
  - Signed overflow case (0x80000000 / -1): LO=0x80000000, HI=0.
- Unknown func, including the all-ones default from alu_control:
  - o_valid=1, o_result=0, o_illegal=1 for one cycle.
  - HI/LO unchanged.
- o_valid, o_done and o_illegal are single-cycle pulses and are low otherwise. o_result holds its last value when o_valid=0.
- o_zero is updated together with o_result.

Decomposition:
- Function codes (ADD, SUBU, AND, OR, XOR, NOR, SLT, SHIFTLUI) stay in defines.v. MULT, MULTU, DIV, DIVU, MFHI, MFLO codes are added there.
- FSM state encodings IDLE/CALC/FIX are localparams in the module.
- One natural sub-module: alu_muldiv_iter, which holds the iterative datapath, counter, sign fix and HI/LO. The top module owns decode, single-cycle ops and the handshake.

Test Plan:
- Reset held 3 cycles, released → all outputs 0, o_ready=1 on next edge; MFLO returns 0.
- ADD 0xFFFFFFFF+1 → o_result=0, o_zero=1. SUBU 5-7 → 0xFFFFFFFE. SLT -1<1 → 1. SHIFTLUI b=0x1234 → 0x12340000. Back-to-back, one o_valid per cycle.
- MULT 0xFFFFFFFE × 3:
  - o_ready low 33 cycles, o_done on cycle 33.
  - MFHI → 0xFFFFFFFF, MFLO → 0xFFFFFFFA.
  - MULTU same operands → HI=2, LO=0xFFFFFFFA.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. i_valid held during busy is accepted only when o_ready returns.
- func=6'b111111 → o_valid=1, o_result=0, o_illegal=1; HI/LO unchanged.
- Reset asserted at cycle 10 of a DIV → o_ready=1 after release, o_done never pulses, MFHI=0, MFLO=0.
